count_seq_ctrl: RTL and testbench

- Sequencer for a WIDTH-bit up-counter with enable and synchronous clear. The counter is the datapath; this block is its controller.
- On a start request the block clears the counter, then issues exactly LEN enable pulses. It supports pause and abort, and signals completion with a one-cycle done pulse.
- Sits between a requesting master (test FSM or CPU-side register) and the counter datapath.

---
 rtl/count_seq_pkg.sv | 21 ++
 rtl/count_seq_dp.sv | 57 +++++
 rtl/count_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_count_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared types and default constants for the count sequencer
//
// Contents:
//   seq_state_t  : controller state encoding (IDLE, CLEAR, RUN, DONE)
//   DEF_WIDTH    : default counter width
//   DEF_LEN_W    : default width of the programmed increment count
//   DEF_WRAP_W   : default width of the wrap-around statistic
package count_seq_pkg;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_WRAP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/count_seq_dp.sv
// rtl/count_seq_dp.sv - up-counter datapath with clear/enable and optional wrap statistic
//
// Optional feature macro: COUNT_SEQ_WRAP_STAT_EN (wrap statistic register built
// only when defined; otherwise wraps is tied to zero).
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear of count (and wraps)
//   en       in   increment enable
//   count    out  WIDTH-bit counter value
//   wraps    out  WRAP_W-bit saturating wrap-around count
module count_seq_dp
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  output logic [WIDTH-1:0]  count,
  output logic [WRAP_W-1:0] wraps
);

  // Clear wins over enable; the controller never asserts both together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

`ifdef COUNT_SEQ_WRAP_STAT_EN
  logic wrap_hit;

  // A wrap is the increment that takes the all-ones value back to zero.
  assign wrap_hit = en && (count == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wraps <= '0;
    end else if (clr) begin
      wraps <= '0;
    end else if (wrap_hit && (wraps != '1)) begin
      wraps <= wraps + 1'b1;
    end
  end
`else
  assign wraps = '0;
`endif

endmodule

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - sequencer that clears a counter then issues LEN enables
//
// Optional feature macro: COUNT_SEQ_WRAP_STAT_EN (enables the wrap statistic in
// the datapath; when undefined wraps reads zero).
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   sequence request, sampled only in IDLE
//   len      in   number of increments, latched on accepted start
//   pause    in   level, freezes counting while high in RUN
//   abort    in   level, terminates the sequence (highest priority)
//   busy     out  high in CLEAR and RUN
//   done     out  one-cycle pulse on normal completion
//   aborted  out  one-cycle pulse in the first IDLE cycle after an abort
//   cnt_en   out  enable currently driven to the counter
//   count    out  counter value
//   wraps    out  saturating count of counter wrap-arounds
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              pause,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cnt_en,
  output logic [WIDTH-1:0]  count,
  output logic [WRAP_W-1:0] wraps
);

  seq_state_t       state;
  logic [LEN_W-1:0] remaining;
  logic             clr;

  // The counter enable must follow pause/abort in the same cycle, so it is
  // decoded from state rather than registered like the other outputs.
  assign cnt_en = (state == RUN) && !abort && !pause;
  assign clr    = (state == CLEAR);

  // busy/done/aborted are registered alongside the state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              remaining <= len;
              state     <= CLEAR;
              busy      <= 1'b1;
            end else begin
              // Zero-length request completes immediately without counting.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        CLEAR: begin
          // The clear itself happens this cycle regardless of abort.
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (!pause) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          // start is deliberately not sampled here.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  count_seq_dp #(
    .WIDTH  (WIDTH),
    .WRAP_W (WRAP_W)
  ) u_dp (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (cnt_en),
    .count   (count),
    .wraps   (wraps)
  );

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - self-checking bench for count_seq_ctrl
module tb_count_seq_ctrl;

  localparam int WIDTH  = 3;
  localparam int LEN_W  = 8;
  localparam int WRAP_W = 4;
  localparam int MODV   = 1 << WIDTH;
  localparam int WMAX   = (1 << WRAP_W) - 1;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              pause;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              cnt_en;
  logic [WIDTH-1:0]  count;
  logic [WRAP_W-1:0] wraps;

  int tests;
  int fails;
  int model_count;

  count_seq_ctrl #(
    .WIDTH  (WIDTH),
    .LEN_W  (LEN_W),
    .WRAP_W (WRAP_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .len     (len),
    .pause   (pause),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .cnt_en  (cnt_en),
    .count   (count),
    .wraps   (wraps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counter starts from zero after CLEAR, so wraps is just whole laps.
  function automatic int exp_wraps(input int incs);
`ifdef COUNT_SEQ_WRAP_STAT_EN
    return ((incs / MODV) > WMAX) ? WMAX : (incs / MODV);
`else
    return 0;
`endif
  endfunction

  // One start request; pause is either random or a fixed window of offsets,
  // abort_after >= 0 aborts once that many increments have been issued.
  task automatic run_seq(input int l, input bit rnd_pause, input int pst, input int pln,
                         input int abort_after, input bit glitch_start);
    int  incs;
    int  npause;
    bit  p;
    bit  ab;
    bit  fin;
    incs   = 0;
    npause = 0;
    fin    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
    if (l == 0) begin
      #1;
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_cnt_en", cnt_en, 0);
      chk("len0_count", count, model_count);
      @(negedge clk);
      #1;
      chk("len0_done_drop", done, 0);
      chk("len0_busy_after", busy, 0);
      return;
    end
    for (int k = 1; k < 400; k++) begin
      if (k == 1) p = 1'b0;
      else if (rnd_pause) p = ($urandom % 4) == 0;
      else p = (k >= pst) && (k < pst + pln);
      ab = (abort_after >= 0) && (k >= 2) && (incs == abort_after);
      pause = p;
      abort = ab;
      if (glitch_start && k == 3) begin
        start = 1'b1;
        len   = 8'd1;
      end
      #1;
      if (k == 1) begin
        chk("clear_busy", busy, 1);
        chk("clear_cnt_en", cnt_en, 0);
        chk("clear_done", done, 0);
      end else if (incs < l) begin
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_aborted", aborted, 0);
        chk("run_count", count, incs % MODV);
        chk("run_cnt_en", cnt_en, (!p && !ab) ? 1 : 0);
        if (ab) begin
          @(negedge clk);
          abort = 1'b0;
          pause = 1'b0;
          start = 1'b0;
          #1;
          chk("abort_pulse", aborted, 1);
          chk("abort_busy", busy, 0);
          chk("abort_done", done, 0);
          chk("abort_count", count, incs % MODV);
          chk("abort_wraps", wraps, exp_wraps(incs));
          @(negedge clk);
          #1;
          chk("abort_pulse_drop", aborted, 0);
          chk("abort_no_done", done, 0);
          chk("abort_count_hold", count, incs % MODV);
          model_count = incs % MODV;
          return;
        end
        if (!p) incs++;
        else npause++;
      end else begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_cnt_en", cnt_en, 0);
        chk("done_cycle", k, 2 + l + npause);
        fin = 1'b1;
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    if (!fin) chk("done_timeout", 0, 1);
    pause = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    #1;
    chk("done_drop", done, 0);
    chk("final_count", count, l % MODV);
    chk("final_wraps", wraps, exp_wraps(l));
    model_count = l % MODV;
  endtask

  initial begin
    int l;
    int ab;
    tests       = 0;
    fails       = 0;
    model_count = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    len         = '0;
    pause       = 1'b0;
    abort       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_count", count, 0);
    chk("rst_wraps", wraps, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_seq(5, 1'b0, 0, 0, -1, 1'b0);
    run_seq(10, 1'b0, 0, 0, -1, 1'b0);
    run_seq(4, 1'b0, 3, 3, -1, 1'b0);
    run_seq(6, 1'b0, 0, 0, 2, 1'b0);
    run_seq(3, 1'b0, 0, 0, -1, 1'b0);
    run_seq(0, 1'b0, 0, 0, -1, 1'b0);
    run_seq(7, 1'b0, 0, 0, -1, 1'b1);
    run_seq(200, 1'b0, 0, 0, -1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      l  = $urandom_range(0, 40);
      ab = -1;
      if (l > 0 && ($urandom % 3) == 0) ab = $urandom_range(0, l - 1);
      run_seq(l, 1'b1, 0, 0, ab, ($urandom % 2) == 1);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_aborted", aborted, 0);
    chk("mid_rst_cnt_en", cnt_en, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wraps", wraps, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_done", done, 0);
    chk("post_rst_aborted", aborted, 0);
    model_count = 0;
    run_seq(20, 1'b0, 0, 0, -1, 1'b0);
    run_seq(5, 1'b1, 0, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
